// File: rtl/mux_2to1.sv
// Word-wide 2-to-1 multiplexer for datapath selection (ALU operand, PC,
// writeback). select=0 routes din_A, select=1 routes din_B. With REG_OUT=1
// the selected word is captured in an output register cleared by rst.
module mux_2to1 #(
    parameter int unsigned           WIDTH     = 32,
    parameter bit                    REG_OUT   = 1'b0,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] dout,
    input  logic [WIDTH-1:0] din_A,
    input  logic [WIDTH-1:0] din_B,
    input  logic             select
);

    logic [WIDTH-1:0] sel_data;

    // Selection via case so an unknown select yields X instead of quietly
    // falling through to din_A the way an if/else would.
    always_comb begin
        sel_data = 'x;
        case (select)
            1'b0:    sel_data = din_A;
            1'b1:    sel_data = din_B;
            default: sel_data = 'x;
        endcase
    end

    generate
        if (REG_OUT) begin : g_reg
            // Output register: synchronous reset has priority over data.
            always_ff @(posedge clk) begin
                if (rst) begin
                    dout <= RESET_VAL;
                end else begin
                    dout <= sel_data;
                end
            end
        end else begin : g_comb
            // Clock and reset are intentionally ignored in the combinational build.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign dout = sel_data;
        end
    endgenerate

endmodule

// File: tb/tb_mux_2to1.sv
// Directed self-checking bench for mux_2to1: combinational build, registered
// build with zero reset value, and registered build with a non-zero reset value.
module tb_mux_2to1;

    localparam int unsigned W = 32;
    localparam logic [W-1:0] RV = 32'hA5A5_0F0F;

    logic         clk;
    logic         rst;
    logic [W-1:0] din_A;
    logic [W-1:0] din_B;
    logic         select;
    logic [W-1:0] dout_comb;
    logic [W-1:0] dout_reg;
    logic [W-1:0] dout_regv;

    int unsigned n_checks;
    int unsigned n_fail;

    mux_2to1 #(.WIDTH(W), .REG_OUT(1'b0)) u_comb (
        .clk(clk), .rst(rst), .dout(dout_comb),
        .din_A(din_A), .din_B(din_B), .select(select)
    );

    mux_2to1 #(.WIDTH(W), .REG_OUT(1'b1)) u_reg (
        .clk(clk), .rst(rst), .dout(dout_reg),
        .din_A(din_A), .din_B(din_B), .select(select)
    );

    mux_2to1 #(.WIDTH(W), .REG_OUT(1'b1), .RESET_VAL(RV)) u_regv (
        .clk(clk), .rst(rst), .dout(dout_regv),
        .din_A(din_A), .din_B(din_B), .select(select)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] pat;
        n_checks = 0;
        n_fail   = 0;
        rst    = 1'b0;
        select = 1'b0;
        din_A  = 32'hDEADBEEF;
        din_B  = 32'hF00DCAFE;

        // Combinational selection
        #20;
        check("comb_sel0", dout_comb, 32'hDEADBEEF);
        select = 1'b1;
        #20;
        check("comb_sel1", dout_comb, 32'hF00DCAFE);
        @(negedge clk);
        select = 1'b0;
        #1;
        check("comb_back_to_A_no_edge", dout_comb, 32'hDEADBEEF);

        // Reset has no effect on the combinational build
        rst    = 1'b1;
        select = 1'b1;
        #1;
        check("comb_rst_sel1", dout_comb, 32'hF00DCAFE);

        // Registered build: reset for two edges
        tick();
        check("reg_rst_edge1", dout_reg, 32'h0);
        check("regv_rst_edge1", dout_regv, RV);
        tick();
        check("reg_rst_edge2", dout_reg, 32'h0);
        check("regv_rst_edge2", dout_regv, RV);
        check("comb_rst_after_edges", dout_comb, 32'hF00DCAFE);

        // Release reset; output holds until the next edge
        rst    = 1'b0;
        select = 1'b0;
        din_A  = 32'h12345678;
        #1;
        check("reg_hold_before_edge", dout_reg, 32'h0);
        check("comb_new_A", dout_comb, 32'h12345678);
        tick();
        check("reg_first_load", dout_reg, 32'h12345678);
        check("regv_first_load", dout_regv, 32'h12345678);

        // select changes between edges: held until next edge
        #2;
        select = 1'b1;
        #1;
        check("reg_sel_change_held", dout_reg, 32'h12345678);
        check("comb_sel_change_now", dout_comb, 32'hF00DCAFE);
        tick();
        check("reg_sel_change_loaded", dout_reg, 32'hF00DCAFE);

        // Simultaneous select + data change
        select = 1'b0;
        din_A  = 32'h0BAD_F00D;
        din_B  = 32'h1111_2222;
        #1;
        check("comb_simul", dout_comb, 32'h0BAD_F00D);
        check("reg_simul_held", dout_reg, 32'hF00DCAFE);
        tick();
        check("reg_simul_loaded", dout_reg, 32'h0BAD_F00D);

        // Reset priority over data, then mid-stream release
        rst    = 1'b1;
        select = 1'b1;
        tick();
        check("reg_rst_priority", dout_reg, 32'h0);
        check("regv_rst_priority", dout_regv, RV);
        rst = 1'b0;
        tick();
        check("reg_rst_release", dout_reg, 32'h1111_2222);
        check("regv_rst_release", dout_regv, 32'h1111_2222);
        tick();
        check("reg_hold_steady", dout_reg, 32'h1111_2222);

        // All-0s / all-1s on each input with both selects
        din_A = 32'h0000_0000; din_B = 32'hFFFF_FFFF; select = 1'b0;
        tick();
        check("zeros_A_comb", dout_comb, 32'h0000_0000);
        check("zeros_A_reg", dout_reg, 32'h0000_0000);
        select = 1'b1;
        tick();
        check("ones_B_comb", dout_comb, 32'hFFFF_FFFF);
        check("ones_B_reg", dout_reg, 32'hFFFF_FFFF);
        din_A = 32'hFFFF_FFFF; din_B = 32'h0000_0000;
        tick();
        check("zeros_B_comb", dout_comb, 32'h0000_0000);
        check("zeros_B_reg", dout_reg, 32'h0000_0000);
        select = 1'b0;
        tick();
        check("ones_A_comb", dout_comb, 32'hFFFF_FFFF);
        check("ones_A_reg", dout_reg, 32'hFFFF_FFFF);

        // Walking-1 on A against walking-0 on B, both selects
        for (int i = 0; i < W; i++) begin
            pat    = 32'h1 << i;
            din_A  = pat;
            din_B  = ~pat;
            select = 1'b0;
            tick();
            check($sformatf("walk_A_comb_%0d", i), dout_comb, pat);
            check($sformatf("walk_A_reg_%0d", i), dout_reg, pat);
            select = 1'b1;
            tick();
            check($sformatf("walk_B_comb_%0d", i), dout_comb, ~pat);
            check($sformatf("walk_B_reg_%0d", i), dout_reg, ~pat);
        end

        // Walking-1 on B against all-0 A
        for (int i = 0; i < W; i++) begin
            pat    = 32'h1 << i;
            din_A  = 32'h0;
            din_B  = pat;
            select = 1'b1;
            tick();
            check($sformatf("walkB1_reg_%0d", i), dout_reg, pat);
            check($sformatf("walkB1_regv_%0d", i), dout_regv, pat);
            select = 1'b0;
            #1;
            check($sformatf("walkB1_comb_A_%0d", i), dout_comb, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
